// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM state encoding and default latency.
// Optional statistics are enabled with the DMEM_RESP_STATS_EN macro (see dmem_responder).
package dmem_pkg;

   localparam int unsigned STATE_BITS      = 2;
   localparam int unsigned CNT_WIDTH       = 4;
   localparam int unsigned DEFAULT_LATENCY = 2;

   localparam logic [STATE_BITS-1:0] IDLE = 2'd0;
   localparam logic [STATE_BITS-1:0] BUSY = 2'd1;
   localparam logic [STATE_BITS-1:0] RESP = 2'd2;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed storage array for dmem_responder: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module dmem_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_BITS-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned Words = 2 ** DEPTH_BITS;

   logic [DATA_WIDTH-1:0] mem_q [Words];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency single-outstanding data-memory responder (IDLE -> BUSY -> RESP).
// Define DMEM_RESP_STATS_EN to add read/write/stall counters and a report printout.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned CORE           = 0,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDRESS_BITS   = 20,
   parameter int unsigned MEM_DEPTH_BITS = 10,
   parameter int unsigned LATENCY        = DEFAULT_LATENCY
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDRESS_BITS-1:0] address,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic [ADDRESS_BITS-1:0] out_addr,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    valid,
   output logic                    ready,
   input  logic                    report
);

   // With unit latency the response is formed at the accept edge straight from the inputs.
   localparam bit          Direct   = (LATENCY == 1);
   localparam int unsigned BusyLoad = (LATENCY > 1) ? (LATENCY - 2) : 0;

   logic [STATE_BITS-1:0]   state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    is_write_q;
   logic [ADDRESS_BITS-1:0] addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    valid_q, valid_d;
   logic                    ready_q, ready_d;
   logic [ADDRESS_BITS-1:0] out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

   logic                    accept_c;
   logic                    enter_resp_c;
   logic                    resp_write_c;
   logic [ADDRESS_BITS-1:0] resp_addr_c;
   logic [DATA_WIDTH-1:0]   resp_wdata_c;
   logic                    ram_we_c;
   logic [DATA_WIDTH-1:0]   ram_rdata_c;

   assign accept_c     = (state_q == IDLE) && (read || write);
   assign resp_write_c = Direct ? write   : is_write_q;
   assign resp_addr_c  = Direct ? address : addr_q;
   assign resp_wdata_c = Direct ? in_data : wdata_q;
   assign ram_we_c     = enter_resp_c && resp_write_c;

   dmem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_BITS (MEM_DEPTH_BITS)
   ) u_ram (
      .clk     (clock),
      .we_i    (ram_we_c),
      .addr_i  (resp_addr_c[MEM_DEPTH_BITS+1:2]),
      .wdata_i (resp_wdata_c),
      .rdata_o (ram_rdata_c)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         valid_q    <= 1'b0;
         ready_q    <= 1'b1;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         ready_q    <= ready_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         if (accept_c) begin
            is_write_q <= write;
            addr_q     <= address;
            wdata_q    <= in_data;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      enter_resp_c = 1'b0;
      valid_d      = valid_q;
      out_addr_d   = out_addr_q;
      out_data_d   = out_data_q;

      case (state_q)
         IDLE: begin
            if (read || write) begin
               if (Direct) begin
                  state_d      = RESP;
                  enter_resp_c = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_WIDTH'(BusyLoad);
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d      = RESP;
               enter_resp_c = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (!stall) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Response registers load on RESP entry and hold while the initiator stalls.
      if (enter_resp_c) begin
         valid_d    = 1'b1;
         out_addr_d = resp_addr_c;
         out_data_d = resp_write_c ? resp_wdata_c : ram_rdata_c;
      end else if ((state_q == RESP) && !stall) begin
         valid_d = 1'b0;
      end

      ready_d = (state_d == IDLE);
   end

   assign valid    = valid_q;
   assign ready    = ready_q;
   assign out_addr = out_addr_q;
   assign out_data = out_data_q;

`ifdef DMEM_RESP_STATS_EN
   logic [31:0] cyc_q;
   logic [31:0] n_rd_q;
   logic [31:0] n_wr_q;
   logic [31:0] n_stall_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cyc_q     <= '0;
         n_rd_q    <= '0;
         n_wr_q    <= '0;
         n_stall_q <= '0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
         if (accept_c && !write) begin
            n_rd_q <= n_rd_q + 32'd1;
         end
         if (accept_c && write) begin
            n_wr_q <= n_wr_q + 32'd1;
         end
         if ((state_q == RESP) && stall) begin
            n_stall_q <= n_stall_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (report) begin
         $display("dmem core %0d cycle %0d state %0d reads %0d writes %0d stall_cycles %0d",
                  CORE, cyc_q, state_q, n_rd_q, n_wr_q, n_stall_q);
      end
   end
`else
   logic unused_c;
   assign unused_c = ^{report, 32'(CORE)};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance and a LATENCY=1 instance
// checked against a word-array model of the memory and the request/response timing rules.
module tb_dmem_responder;

   localparam int unsigned AW    = 20;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 1024;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset;
   logic          stall, read, write, report;
   logic [AW-1:0] address;
   logic [DW-1:0] in_data;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          valid, ready;

   logic          b_stall, b_read, b_write;
   logic [AW-1:0] b_address;
   logic [DW-1:0] b_in_data;
   logic [AW-1:0] b_out_addr;
   logic [DW-1:0] b_out_data;
   logic          b_valid, b_ready;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] ref_mem [int];

   dmem_responder #(
      .CORE (0), .DATA_WIDTH (DW), .ADDRESS_BITS (AW), .MEM_DEPTH_BITS (10), .LATENCY (2)
   ) dut (
      .clock (clock), .reset (reset), .stall (stall), .read (read), .write (write),
      .address (address), .in_data (in_data), .out_addr (out_addr), .out_data (out_data),
      .valid (valid), .ready (ready), .report (report)
   );

   dmem_responder #(
      .CORE (1), .DATA_WIDTH (DW), .ADDRESS_BITS (AW), .MEM_DEPTH_BITS (10), .LATENCY (1)
   ) dut1 (
      .clock (clock), .reset (reset), .stall (b_stall), .read (b_read), .write (b_write),
      .address (b_address), .in_data (b_in_data), .out_addr (b_out_addr), .out_data (b_out_data),
      .valid (b_valid), .ready (b_ready), .report (1'b0)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [AW-1:0] a);
      return int'((int'(a) / 4) % DEPTH);
   endfunction

   // One LATENCY=2 transaction: accept, expect valid two cycles later, optional stall hold.
   task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int nstall, input string tag);
      int            k;
      int            w;
      logic [DW-1:0] exp_d;
      w     = widx(a);
      exp_d = wr ? d : ref_mem[w];
      k = 0;
      while (!ready && k < 20) begin
         @(negedge clock);
         k++;
      end
      chk({tag, "_ready_in"}, 64'(ready), 64'd1);
      read = rd; write = wr; address = a; in_data = d;
      @(negedge clock);
      read = 1'b0; write = 1'b0;
      if (wr) ref_mem[w] = d;
      k = 1;
      while (!valid && k < 20) begin
         @(negedge clock);
         k++;
      end
      chk({tag, "_latency"}, 64'(k), 64'd2);
      chk({tag, "_addr"}, 64'(out_addr), 64'(a));
      chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
      chk({tag, "_ready_resp"}, 64'(ready), 64'd0);
      for (int i = 0; i < nstall; i++) begin
         stall  = 1'b1;
         report = (i == 0);
         @(negedge clock);
         chk({tag, "_stall_valid"}, 64'(valid), 64'd1);
         chk({tag, "_stall_data"}, 64'(out_data), 64'(exp_d));
         chk({tag, "_stall_addr"}, 64'(out_addr), 64'(a));
         chk({tag, "_stall_ready"}, 64'(ready), 64'd0);
      end
      stall  = 1'b0;
      report = 1'b0;
      @(negedge clock);
      chk({tag, "_valid_drop"}, 64'(valid), 64'd0);
      chk({tag, "_ready_back"}, 64'(ready), 64'd1);
   endtask

   initial begin
      logic [DW-1:0] bmem [8];
      bit            bknown [8];
      bit            pend;
      bit            accept_now;
      logic [AW-1:0] p_addr;
      logic [DW-1:0] p_data;
      int            op;
      int            w;
      logic [AW-1:0] a;

      reset = 1'b0; stall = 1'b0; read = 1'b0; write = 1'b0; report = 1'b0;
      address = '0; in_data = '0;
      b_stall = 1'b0; b_read = 1'b0; b_write = 1'b0; b_address = '0; b_in_data = '0;
      for (int i = 0; i < 8; i++) bknown[i] = 1'b0;

      @(negedge clock);
      @(negedge clock);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_b_valid", 64'(b_valid), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd1);
      reset = 1'b1;
      @(negedge clock);

      // LATENCY=1 instance: continuous random requests; only IDLE cycles accept.
      pend = 1'b0;
      p_addr = '0;
      p_data = '0;
      for (int c = 0; c < 40; c++) begin
         if (pend) begin
            chk("l1_valid", 64'(b_valid), 64'd1);
            chk("l1_addr", 64'(b_out_addr), 64'(p_addr));
            chk("l1_data", 64'(b_out_data), 64'(p_data));
            chk("l1_ready_resp", 64'(b_ready), 64'd0);
         end else begin
            chk("l1_idle_valid", 64'(b_valid), 64'd0);
            chk("l1_idle_ready", 64'(b_ready), 64'd1);
         end
         accept_now = !pend;
         op = int'($urandom_range(0, 3));
         w  = int'($urandom_range(0, 7));
         if (op == 1 && !bknown[w]) op = 2;
         b_address = AW'((int'($urandom_range(0, 255)) << 12) | (w << 2) | int'($urandom_range(0, 3)));
         b_in_data = $urandom;
         b_read    = (op == 1) || (op == 3);
         b_write   = (op >= 2);
         pend      = accept_now && (op != 0);
         if (pend) begin
            p_addr = b_address;
            if (op >= 2) begin
               p_data    = b_in_data;
               bmem[w]   = b_in_data;
               bknown[w] = 1'b1;
            end else begin
               p_data = bmem[w];
            end
         end
         @(negedge clock);
      end
      b_read = 1'b0; b_write = 1'b0;
      if (pend) begin
         chk("l1_last_valid", 64'(b_valid), 64'd1);
         chk("l1_last_data", 64'(b_out_data), 64'(p_data));
      end
      @(negedge clock);

      // LATENCY=2 directed cases.
      do_req(1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, 0, "w10");
      do_req(1'b1, 1'b0, 20'h00010, 32'h0, 0, "r10");
      do_req(1'b0, 1'b1, 20'h00010, 32'hA5A5A5A5, 0, "w10b");
      do_req(1'b1, 1'b0, 20'h00013, 32'h0, 0, "r13");
      do_req(1'b1, 1'b0, 20'h01010, 32'h0, 0, "r1010_alias");
      do_req(1'b1, 1'b0, 20'h00010, 32'h0, 3, "stall3");
      do_req(1'b1, 1'b1, 20'h00020, 32'h00001234, 0, "rw20");
      do_req(1'b1, 1'b0, 20'h00020, 32'h0, 0, "r20");

      // Reset while a write is still in BUSY must drop it.
      do_req(1'b0, 1'b1, 20'h00040, 32'h11111111, 0, "w40");
      write = 1'b1; address = 20'h00040; in_data = 32'h00000055;
      @(negedge clock);
      write = 1'b0;
      chk("busy_ready", 64'(ready), 64'd0);
      chk("busy_valid", 64'(valid), 64'd0);
      #2 reset = 1'b0;
      #1;
      chk("midrst_valid", 64'(valid), 64'd0);
      chk("midrst_ready", 64'(ready), 64'd1);
      chk("midrst_out_data", 64'(out_data), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      do_req(1'b1, 1'b0, 20'h00040, 32'h0, 0, "r40_kept");

      // Random traffic with aliasing upper bits and random stalls.
      for (int i = 0; i < 24; i++) begin
         logic rd, wr;
         w  = int'($urandom_range(0, 15));
         a  = AW'((int'($urandom_range(0, 255)) << 12) | (w << 2) | int'($urandom_range(0, 3)));
         op = int'($urandom_range(1, 3));
         if (op == 1 && !ref_mem.exists(w)) op = 2;
         rd = (op == 1) || (op == 3);
         wr = (op >= 2);
         do_req(rd, wr, a, $urandom, int'($urandom_range(0, 2)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
